// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : Control-side pipeline behind the main decoder. Carries the
//                per-instruction control bundle from ID through EX, MEM and WB,
//                detects load-use hazards (stall + bubble), resolves EX-stage
//                redirects (flush), produces EX operand forwarding selects and
//                keeps saturating stall/flush event counters.
//  Ports       : clk, reset (sync, active-low)
//                id_valid, id_ctrl[9:0], id_rs1/rs2/rd   - ID stage inputs
//                ex_br_cond                              - EX compare result
//                ex_valid, ex_ctrl, ex_rd                - EX stage state
//                mem_valid/memread/memwrite/memtoreg/regwrite, mem_rd
//                wb_valid/memtoreg/regwrite, wb_rd
//                pc_write_en, if_id_write_en, if_id_flush, redirect
//                fwd_a, fwd_b (00 regfile, 10 MEM, 01 WB)
//                stall_cnt, flush_cnt                    - saturating counters
//  id_ctrl     : {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//                 ALUOp[1:0], Branch, jal, jalr}
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipeline #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [9:0]       id_ctrl,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_br_cond,
    output logic             ex_valid,
    output logic [9:0]       ex_ctrl,
    output logic [RA_W-1:0]  ex_rd,
    output logic             mem_valid,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_memtoreg,
    output logic             mem_regwrite,
    output logic [RA_W-1:0]  mem_rd,
    output logic             wb_valid,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [RA_W-1:0]  wb_rd,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             redirect,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Bit positions inside the control bundle
    localparam int c_MEMTOREG = 8;
    localparam int c_REGWRITE = 7;
    localparam int c_MEMREAD  = 6;
    localparam int c_MEMWRITE = 5;
    localparam int c_BRANCH   = 2;
    localparam int c_JAL      = 1;
    localparam int c_JALR     = 0;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RA_W-1:0]  c_X0      = '0;

    // EX stage
    logic             r_ex_valid;
    logic [9:0]       r_ex_ctrl;
    logic [RA_W-1:0]  r_ex_rs1;
    logic [RA_W-1:0]  r_ex_rs2;
    logic [RA_W-1:0]  r_ex_rd;
    // MEM stage
    logic             r_mem_valid;
    logic             r_mem_memread;
    logic             r_mem_memwrite;
    logic             r_mem_memtoreg;
    logic             r_mem_regwrite;
    logic [RA_W-1:0]  r_mem_rd;
    // WB stage
    logic             r_wb_valid;
    logic             r_wb_memtoreg;
    logic             r_wb_regwrite;
    logic [RA_W-1:0]  r_wb_rd;
    // Counters
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_hazard;
    logic             w_redirect;
    logic             w_bubble;
    logic             w_mem_fwd_ok;
    logic             w_wb_fwd_ok;

    // ------------------------------------------------------------------
    // Hazard / redirect detection
    // ------------------------------------------------------------------
    always_comb begin
        w_hazard   = r_ex_valid & r_ex_ctrl[c_MEMREAD] & (r_ex_rd != c_X0) & id_valid &
                     ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
        w_redirect = r_ex_valid & ((r_ex_ctrl[c_BRANCH] & ex_br_cond) |
                                   r_ex_ctrl[c_JAL] | r_ex_ctrl[c_JALR]);
        // A redirect kills the wrong-path ID instruction, so any hazard it
        // raised is irrelevant and the front end keeps moving.
        w_bubble   = w_redirect | w_hazard | ~id_valid;
    end

    assign pc_write_en    = w_redirect | ~w_hazard;
    assign if_id_write_en = w_redirect | ~w_hazard;
    assign if_id_flush    = w_redirect;
    assign redirect       = w_redirect;

    // ------------------------------------------------------------------
    // Forwarding selects (MEM wins over WB; x0 never forwards)
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_fwd_ok = r_mem_valid & r_mem_regwrite & (r_mem_rd != c_X0);
        w_wb_fwd_ok  = r_wb_valid & r_wb_regwrite & (r_wb_rd != c_X0);
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_ex_valid) begin
            if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1))     fwd_a = 2'b10;
            else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1))  fwd_a = 2'b01;
            if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2))     fwd_b = 2'b10;
            else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2))  fwd_b = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers. Bubbles are stored with all-zero fields, so every
    // downstream control is naturally zero for an invalid stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
                r_ex_rs1   <= '0;
                r_ex_rs2   <= '0;
                r_ex_rd    <= '0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= id_ctrl;
                r_ex_rs1   <= id_rs1;
                r_ex_rs2   <= id_rs2;
                r_ex_rd    <= id_rd;
            end

            r_mem_valid    <= r_ex_valid;
            r_mem_memread  <= r_ex_ctrl[c_MEMREAD];
            r_mem_memwrite <= r_ex_ctrl[c_MEMWRITE];
            r_mem_memtoreg <= r_ex_ctrl[c_MEMTOREG];
            r_mem_regwrite <= r_ex_ctrl[c_REGWRITE];
            r_mem_rd       <= r_ex_rd;

            r_wb_valid     <= r_mem_valid;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_rd        <= r_mem_rd;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_redirect && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_rd        = r_ex_rd;
    assign mem_valid    = r_mem_valid;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_memtoreg = r_mem_memtoreg;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_rd       = r_mem_rd;
    assign wb_valid     = r_wb_valid;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_rd        = r_wb_rd;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Self-checking bench for ctrl_pipeline. A slot-based model of
//                the in-flight instructions predicts every output each cycle;
//                directed sequences add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipeline;

    localparam int RA_W  = 5;
    localparam int CNT_W = 2;
    localparam int c_CNT_MAX = (1 << CNT_W) - 1;

    // Control bundles {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Branch,jal,jalr}
    localparam logic [9:0] c_LW     = 10'b1111_0_00_000;
    localparam logic [9:0] c_ADD    = 10'b0010_0_10_000;
    localparam logic [9:0] c_BEQ    = 10'b0000_0_01_100;
    localparam logic [9:0] c_JAL    = 10'b0010_0_00_010;
    localparam logic [9:0] c_JALR   = 10'b1010_0_00_001;
    localparam logic [9:0] c_LW_JAL = 10'b1111_0_00_010;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [9:0]       id_ctrl;
    logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
    logic             ex_br_cond;
    logic             ex_valid;
    logic [9:0]       ex_ctrl;
    logic [RA_W-1:0]  ex_rd;
    logic             mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [RA_W-1:0]  mem_rd;
    logic             wb_valid, wb_memtoreg, wb_regwrite;
    logic [RA_W-1:0]  wb_rd;
    logic             pc_write_en, if_id_write_en, if_id_flush, redirect;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    ctrl_pipeline #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_br_cond(ex_br_cond),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .redirect(redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: one record per in-flight instruction; index 0=EX, 1=MEM, 2=WB
    // ------------------------------------------------------------------
    typedef struct {
        bit         valid;
        bit         memtoreg, regwrite, memread, memwrite, branch, jal, jalr;
        logic [9:0] ctrl;
        int         rs1, rs2, rd;
    } slot_t;

    slot_t ms [3];
    int    m_stall;
    int    m_flush;
    bit    m_init = 1'b0;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.memtoreg = 0; s.regwrite = 0; s.memread = 0; s.memwrite = 0;
        s.branch = 0; s.jal = 0; s.jalr = 0; s.ctrl = '0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        return s;
    endfunction

    function automatic slot_t decode(input logic [9:0] c, input int r1, input int r2, input int rd);
        slot_t s;
        s = empty_slot();
        s.valid = 1; s.ctrl = c;
        s.memtoreg = c[8]; s.regwrite = c[7]; s.memread = c[6]; s.memwrite = c[5];
        s.branch = c[2]; s.jal = c[1]; s.jalr = c[0];
        s.rs1 = r1; s.rs2 = r2; s.rd = rd;
        return s;
    endfunction

    // Taken control transfer sitting in EX
    function automatic bit m_redirect();
        return ms[0].valid && ((ms[0].branch && ex_br_cond) || ms[0].jal || ms[0].jalr);
    endfunction

    // Load in EX whose (non-x0) destination the ID instruction reads
    function automatic bit m_hazard();
        return ms[0].valid && ms[0].memread && ms[0].rd != 0 && id_valid &&
               (ms[0].rd == int'(id_rs1) || ms[0].rd == int'(id_rs2));
    endfunction

    function automatic logic [1:0] m_fwd(input int rs);
        if (!ms[0].valid) return 2'b00;
        if (ms[1].valid && ms[1].regwrite && ms[1].rd != 0 && ms[1].rd == rs) return 2'b10;
        if (ms[2].valid && ms[2].regwrite && ms[2].rd != 0 && ms[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Model advance on every active edge
    always @(posedge clk) begin
        bit rd_now, hz_now;
        if (!reset) begin
            for (int i = 0; i < 3; i++) ms[i] = empty_slot();
            m_stall = 0;
            m_flush = 0;
            m_init  = 1'b1;
        end else if (m_init) begin
            rd_now = m_redirect();
            hz_now = m_hazard();
            if (hz_now && m_stall < c_CNT_MAX) m_stall++;
            if (rd_now && m_flush < c_CNT_MAX) m_flush++;
            ms[2] = ms[1];
            ms[1] = ms[0];
            if (id_valid && !rd_now && !hz_now)
                ms[0] = decode(id_ctrl, int'(id_rs1), int'(id_rs2), int'(id_rd));
            else
                ms[0] = empty_slot();
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        bit rd_now, hz_now;
        if (m_init) begin
            rd_now = m_redirect();
            hz_now = m_hazard();
            chk("ex_valid",     32'(ex_valid),     32'(ms[0].valid));
            chk("ex_ctrl",      32'(ex_ctrl),      ms[0].valid ? 32'(ms[0].ctrl) : 32'd0);
            if (ms[0].valid) chk("ex_rd", 32'(ex_rd), 32'(ms[0].rd));
            chk("mem_valid",    32'(mem_valid),    32'(ms[1].valid));
            chk("mem_memread",  32'(mem_memread),  32'(ms[1].valid && ms[1].memread));
            chk("mem_memwrite", 32'(mem_memwrite), 32'(ms[1].valid && ms[1].memwrite));
            chk("mem_memtoreg", 32'(mem_memtoreg), 32'(ms[1].valid && ms[1].memtoreg));
            chk("mem_regwrite", 32'(mem_regwrite), 32'(ms[1].valid && ms[1].regwrite));
            if (ms[1].valid) chk("mem_rd", 32'(mem_rd), 32'(ms[1].rd));
            chk("wb_valid",     32'(wb_valid),     32'(ms[2].valid));
            chk("wb_memtoreg",  32'(wb_memtoreg),  32'(ms[2].valid && ms[2].memtoreg));
            chk("wb_regwrite",  32'(wb_regwrite),  32'(ms[2].valid && ms[2].regwrite));
            if (ms[2].valid) chk("wb_rd", 32'(wb_rd), 32'(ms[2].rd));
            chk("pc_write_en",    32'(pc_write_en),    32'(rd_now || !hz_now));
            chk("if_id_write_en", 32'(if_id_write_en), 32'(rd_now || !hz_now));
            chk("if_id_flush",    32'(if_id_flush),    32'(rd_now));
            chk("redirect",       32'(redirect),       32'(rd_now));
            chk("fwd_a",     32'(fwd_a),     32'(m_fwd(ms[0].rs1)));
            chk("fwd_b",     32'(fwd_b),     32'(m_fwd(ms[0].rs2)));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic set_id(input logic v, input logic [9:0] c,
                          input int r1, input int r2, input int rd);
        id_valid = v;
        id_ctrl  = c;
        id_rs1   = RA_W'(r1);
        id_rs2   = RA_W'(r2);
        id_rd    = RA_W'(rd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        ex_br_cond = 1'b0;
        set_id(1'b1, c_LW, 1, 2, 5);

        // Reset held two cycles with a valid ID instruction
        tick();
        tick();
        chk("rst_ex_valid",  32'(ex_valid),    32'd0);
        chk("rst_mem_valid", 32'(mem_valid),   32'd0);
        chk("rst_wb_valid",  32'(wb_valid),    32'd0);
        chk("rst_stall",     32'(stall_cnt),   32'd0);
        chk("rst_flush",     32'(flush_cnt),   32'd0);
        chk("rst_pc_we",     32'(pc_write_en), 32'd1);
        chk("rst_fwd_a",     32'(fwd_a),       32'd0);
        reset = 1'b1;

        // Load-use: lw x5, then add x7,x5,x6
        set_id(1'b1, c_LW, 1, 2, 5);
        tick();
        set_id(1'b1, c_ADD, 5, 6, 7);
        #1;
        chk("lu_pc_we",    32'(pc_write_en),    32'd0);
        chk("lu_ifid_we",  32'(if_id_write_en), 32'd0);
        tick();
        chk("lu_bub_valid", 32'(ex_valid),    32'd0);
        chk("lu_bub_ctrl",  32'(ex_ctrl),     32'd0);
        chk("lu_mem_rd",    32'(mem_memread), 32'd1);
        chk("lu_stall",     32'(stall_cnt),   32'd1);
        chk("lu_pc_we2",    32'(pc_write_en), 32'd1);
        tick();
        chk("lu_fwd_a", 32'(fwd_a), 32'b01);
        chk("lu_fwd_b", 32'(fwd_b), 32'b00);

        // Forwarding: MEM beats WB
        set_id(1'b1, c_ADD, 1, 2, 3);
        tick();
        tick();
        set_id(1'b1, c_ADD, 3, 3, 4);
        tick();
        chk("fw_a_mem", 32'(fwd_a), 32'b10);
        chk("fw_b_mem", 32'(fwd_b), 32'b10);

        // Same with rd = x0: never forwards
        set_id(1'b1, c_ADD, 1, 2, 0);
        tick();
        tick();
        set_id(1'b1, c_ADD, 0, 0, 4);
        tick();
        chk("fw_a_x0", 32'(fwd_a), 32'b00);
        chk("fw_b_x0", 32'(fwd_b), 32'b00);

        // Branch taken
        set_id(1'b1, c_BEQ, 1, 2, 0);
        tick();
        set_id(1'b1, c_ADD, 1, 2, 8);
        ex_br_cond = 1'b1;
        #1;
        chk("br_redirect", 32'(redirect),    32'd1);
        chk("br_flush",    32'(if_id_flush), 32'd1);
        chk("br_pc_we",    32'(pc_write_en), 32'd1);
        tick();
        ex_br_cond = 1'b0;
        chk("br_ex_bubble", 32'(ex_valid),  32'd0);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

        // Branch not taken
        set_id(1'b1, c_BEQ, 1, 2, 0);
        tick();
        set_id(1'b1, c_ADD, 1, 2, 8);
        #1;
        chk("bnt_redirect", 32'(redirect),    32'd0);
        chk("bnt_flush",    32'(if_id_flush), 32'd0);
        tick();
        chk("bnt_ex_valid", 32'(ex_valid), 32'd1);

        // jal redirects regardless of ex_br_cond
        set_id(1'b1, c_JAL, 0, 0, 1);
        tick();
        set_id(1'b1, c_ADD, 1, 2, 8);
        #1;
        chk("jal_redirect", 32'(redirect), 32'd1);
        tick();

        // Forced hazard + redirect: redirect wins, stall still counted
        set_id(1'b1, c_LW_JAL, 0, 0, 9);
        tick();
        set_id(1'b1, c_ADD, 9, 2, 10);
        #1;
        chk("hr_redirect", 32'(redirect),       32'd1);
        chk("hr_pc_we",    32'(pc_write_en),    32'd1);
        chk("hr_ifid_we",  32'(if_id_write_en), 32'd1);
        chk("hr_flush",    32'(if_id_flush),    32'd1);
        tick();
        chk("hr_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("hr_flush_cnt", 32'(flush_cnt), 32'd3);

        // Mid-stream reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_ex_valid",  32'(ex_valid),  32'd0);
        chk("mr_mem_valid", 32'(mem_valid), 32'd0);
        chk("mr_wb_valid",  32'(wb_valid),  32'd0);
        chk("mr_stall",     32'(stall_cnt), 32'd0);
        chk("mr_flush",     32'(flush_cnt), 32'd0);

        // Five jalr redirects (one every other cycle) saturate at 3
        set_id(1'b1, c_JALR, 1, 0, 1);
        repeat (4) tick();
        chk("sat_flush_2", 32'(flush_cnt), 32'd2);
        repeat (6) tick();
        chk("sat_flush_3", 32'(flush_cnt), 32'd3);

        // Reset again mid-stream
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr2_ex_valid",  32'(ex_valid),  32'd0);
        chk("mr2_mem_valid", 32'(mem_valid), 32'd0);
        chk("mr2_wb_valid",  32'(wb_valid),  32'd0);
        chk("mr2_flush",     32'(flush_cnt), 32'd0);
        set_id(1'b0, c_ADD, 0, 0, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
